// File: rtl/pcs_pkg.sv
// Shared 64B/66B PCS definitions: block/word widths, gearbox period, sync headers.
package pcs_pkg;

  localparam int unsigned BLOCK_W    = 66;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned GB_SEQ_MAX = 32;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // 66-bit block, sync header in [1:0], payload in [65:2].
  typedef logic [BLOCK_W-1:0] pcs_block_t;

  // A sync header is only legal when its two bits differ.
  function automatic logic sh_invalid(logic [1:0] sh);
    return (sh != SH_DATA) && (sh != SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_tx_gearbox.sv
// 66-to-64 transmit gearbox: packs 32 incoming 66-bit blocks into 33 line words.
// Optional feature: define GEARBOX_UNDERFLOW_CNT_EN to add a saturating count of
// idle (underflow) cycles on underflow_cnt_o.
module pcs_tx_gearbox
  import pcs_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          sync_hdr_i,
  input  logic [WORD_W-1:0]   data_in_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [WORD_W-1:0]   data_out_o,
  output logic                out_valid_o,
`ifdef GEARBOX_UNDERFLOW_CNT_EN
  output logic [15:0]         underflow_cnt_o,
`endif
  output logic                hdr_err_o
);

  logic [5:0]   seq_q;
  logic [127:0] res_q;      // residue, 2*seq_q valid bits starting at bit 0
  logic [63:0]  data_q;
  logic         valid_q;
  logic         hdr_err_q;
  pcs_block_t   blk;
  logic [127:0] cat;        // {block, residue}, residue bits transmitted first

`ifdef GEARBOX_UNDERFLOW_CNT_EN
  logic [15:0]  uf_cnt_q;
  assign underflow_cnt_o = uf_cnt_q;
`endif

  assign blk = {data_in_i, sync_hdr_i};
  assign cat = ({62'b0, blk} << {seq_q, 1'b0}) | res_q;

  // Ready depends on state only; the 33rd slot drains the residue.
  always_comb begin
    in_ready_o = !rst_i && (seq_q < 6'(GB_SEQ_MAX));
  end

  // Shift/align state: accept a block, drain the full residue, or hold on underflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q     <= '0;
      res_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      hdr_err_q <= 1'b0;
`ifdef GEARBOX_UNDERFLOW_CNT_EN
      uf_cnt_q  <= '0;
`endif
    end else if (seq_q == 6'(GB_SEQ_MAX)) begin
      data_q    <= res_q[63:0];
      res_q     <= '0;
      seq_q     <= '0;
      valid_q   <= 1'b1;
      hdr_err_q <= 1'b0;
    end else if (in_valid_i) begin
      data_q    <= cat[63:0];
      res_q     <= {64'b0, cat[127:64]};
      seq_q     <= seq_q + 6'd1;
      valid_q   <= 1'b1;
      hdr_err_q <= sh_invalid(sync_hdr_i);
    end else begin
      valid_q   <= 1'b0;
      hdr_err_q <= 1'b0;
`ifdef GEARBOX_UNDERFLOW_CNT_EN
      if (uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
`endif
    end
  end

  assign data_out_o  = data_q;
  assign out_valid_o = valid_q;
  assign hdr_err_o   = hdr_err_q;

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Randomised bench for pcs_tx_gearbox against a bit-queue reference model.
module tb_pcs_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sync_hdr;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_out;
  logic        out_valid;
  logic        hdr_err;
`ifdef GEARBOX_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  pcs_tx_gearbox dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sync_hdr_i (sync_hdr),
    .data_in_i  (data_in),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .data_out_o (data_out),
    .out_valid_o(out_valid),
`ifdef GEARBOX_UNDERFLOW_CNT_EN
    .underflow_cnt_o(underflow_cnt),
`endif
    .hdr_err_o  (hdr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the serial line is a FIFO of bits; blocks push 66, words pop 64.
  bit          bitq[$];
  logic [63:0] exp_data = '0;
  int          exp_uf   = 0;
  logic        obs_ready;
  logic        obs_xfer;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, compare registered outputs.
  task automatic cycle(input logic r, input logic v, input logic [1:0] sh, input logic [63:0] d);
    logic exp_ready, xfer, exp_valid, exp_herr;
    rst = r; in_valid = v; sync_hdr = sh; data_in = d;
    #1;
    exp_ready = !r && (bitq.size() < 64);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    obs_ready = in_ready;
    xfer      = v && exp_ready;
    obs_xfer  = xfer;
    exp_herr  = xfer && (sh == 2'b00 || sh == 2'b11);
    if (r) begin
      bitq.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_uf    = 0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < 2; i++) bitq.push_back(sh[i]);
        for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
      end
      exp_valid = xfer || !exp_ready;
      if (exp_valid) begin
        for (int i = 0; i < 64; i++) exp_data[i] = bitq.pop_front();
      end else if (exp_uf < 65535) begin
        exp_uf++;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("data_out", data_out, exp_data);
    check("hdr_err", 64'(hdr_err), 64'(exp_herr));
`ifdef GEARBOX_UNDERFLOW_CNT_EN
    check("underflow_cnt", 64'(underflow_cnt), 64'(exp_uf));
`endif
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 2'b01, 64'($urandom));
  endtask

  // Feed blocks until the model reaches the requested sequence position.
  task automatic advance_to(input int s);
    int guard = 0;
    while (((bitq.size() / 2) != s) && guard < 100) begin
      cycle(1'b0, 1'b1, 2'b01, {$urandom, $urandom});
      guard++;
    end
    check("advance_bound", 64'(guard < 100), 64'd1);
  endtask

  initial begin
    int xfers, words;
    logic [63:0] held;
    logic [1:0]  sh;

    rst = 1'b1; in_valid = 1'b0; sync_hdr = 2'b01; data_in = '0;

    // Reset for three cycles.
    do_reset(3);
    check("rst_data_out", data_out, 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);

    // First block: all-ones payload behind a data header.
    cycle(1'b0, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    check("first_word", data_out, 64'hFFFF_FFFF_FFFF_FFFD);
    check("first_residue_bits", 64'(bitq.size()), 64'd2);

    // Full 33-cycle period with in_valid held high.
    do_reset(1);
    xfers = 0; words = 0;
    for (int i = 0; i < 33; i++) begin
      cycle(1'b0, 1'b1, 2'b01, 64'(i) * 64'h0101_0101_0101_0101 + 64'h1234);
      if (obs_xfer && obs_ready) xfers++;
      if (out_valid) words++;
      if (i == 32) check("period_ready_low", 64'(obs_ready), 64'd0);
    end
    check("period_xfers", 64'(xfers), 64'd32);
    check("period_words", 64'(words), 64'd33);
    check("period_drained", 64'(bitq.size()), 64'd0);

    // Underflow for 5 cycles at seq=10.
    do_reset(1);
    advance_to(10);
    held = exp_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 2'b10, 64'($urandom));
      check("underflow_hold", data_out, held);
    end
`ifdef GEARBOX_UNDERFLOW_CNT_EN
    check("underflow_cnt5", 64'(underflow_cnt), 64'd5);
`endif
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b01, {$urandom, $urandom});

    // Bad header at seq=7.
    do_reset(1);
    advance_to(7);
    cycle(1'b0, 1'b1, 2'b11, 64'hDEAD_BEEF_0BAD_F00D);
    check("hdr_err_pulse", 64'(hdr_err), 64'd1);
    cycle(1'b0, 1'b1, 2'b01, 64'h0);
    check("hdr_err_single", 64'(hdr_err), 64'd0);

    // Reset pulsed mid-sequence at seq=20.
    advance_to(20);
    do_reset(1);
    cycle(1'b0, 1'b1, 2'b10, 64'hA5A5_5A5A_0F0F_F0F0);
    check("post_rst_hdr", 64'(data_out[1:0]), 64'd2);

    // Random traffic with sparse resets and occasional bad headers.
    for (int i = 0; i < 3000; i++) begin
      sh = 2'($urandom_range(1, 2));
      if ($urandom_range(0, 19) == 0) sh = 2'($urandom);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8), sh,
            {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_tx_gearbox.md
PCS_TX_GEARBOX -- requirements
Module: pcs_tx_gearbox

Interface
REQ-001 CLK  input  1  rising-edge clock; the only clock.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 sync_hdr  input  2  64B/66B sync header of the current block; bit 0 is transmitted first.
REQ-004 data_in  input  64  scrambled payload from the 64-bit scrambler; bit 0 is transmitted first, after sync_hdr.
REQ-005 in_valid  input  1  sync_hdr/data_in carry a block this cycle.
REQ-006 in_ready  output  1  gearbox accepts a block this cycle; combinational from state only.
REQ-007 data_out  output  64  registered 64-bit line word; bit 0 is transmitted first.
REQ-008 out_valid  output  1  registered; data_out is valid.
REQ-009 hdr_err  output  1  registered one-cycle pulse: an accepted block had sync_hdr 2'b00 or 2'b11.

Function
REQ-010 Block B = {data_in, sync_hdr} (66 bits, sync_hdr in B[1:0]); transfer occurs when in_valid && in_ready.
REQ-011 The block SHALL hold state seq (0..32) and residue R of width 2*seq bits, held in a 128-bit buffer.
REQ-012 in_ready SHALL be 1 when seq<32 and RST=0; otherwise 0.
REQ-013 seq<32 with transfer: C={B,R}; data_out<=C[63:0]; R<=C[2*seq+65:64]; seq<=seq+1; out_valid<=1.
REQ-014 seq=32: data_out<=R[63:0]; R<=empty; seq<=0; out_valid<=1; in_valid is ignored.
REQ-015 seq<32 without a transfer (underflow): seq, R and data_out hold; out_valid<=0.
REQ-016 Latency: a word SHALL appear on data_out one cycle after the transfer that completes it.
REQ-017 Throughput: 32 blocks SHALL produce exactly 33 words, with in_ready low for exactly 1 cycle in every 33 while in_valid is held high.
REQ-018 hdr_err<=1 in the cycle after a transfer with sync_hdr in {2'b00,2'b11}; otherwise hdr_err<=0. The block is still passed unchanged.
REQ-019 No bit SHALL be dropped, duplicated or reordered: the concatenated data_out stream equals the concatenated B stream.

Reset
REQ-020 While RST=1 at a clock edge: seq<=0, R<=0, data_out<=64'h0, out_valid<=0, hdr_err<=0.
REQ-021 While RST=1, in_ready SHALL be 0 and any offered block is discarded.
REQ-022 When RST is asserted mid-sequence, the partial residue SHALL be discarded; the first transfer after release is treated as seq=0.

Configuration
REQ-023 Macro GEARBOX_UNDERFLOW_CNT_EN defined: adds output underflow_cnt[15:0], which increments on each REQ-015 cycle, saturates at 16'hFFFF, and resets to 0.
REQ-024 Macro undefined: port and counter are absent; all other behaviour is identical.

Structure
REQ-025 Shared package pcs_pkg SHALL hold BLOCK_W=66, WORD_W=64, GB_SEQ_MAX=32, SH_DATA=2'b01, SH_CTRL=2'b10 and typedef pcs_block_t (66-bit).
REQ-026 The block SHALL be a single module with no sub-module; the shift and align logic stays in a single always_ff plus a combinational in_ready.

Verification
REQ-027 RST high for 3 cycles -> data_out=0, out_valid=0, in_ready=0; one cycle after release, in_ready=1 and seq=0.
REQ-028 First block sync_hdr=2'b01, data_in=64'hFFFF_FFFF_FFFF_FFFF -> next cycle data_out=64'hFFFF_FFFF_FFFF_FFFD, out_valid=1, residue=2'b11.
REQ-029 33 consecutive cycles of in_valid=1 with incrementing payloads -> 32 transfers, in_ready=0 on cycle 33, 33 valid words, and the deserialised stream matches the input exactly.
REQ-030 in_valid dropped for 5 cycles at seq=10 -> out_valid=0 for those 5 cycles, data_out held, alignment correct on resume; with the macro defined, underflow_cnt=5.
REQ-031 Block with sync_hdr=2'b11 at seq=7 -> hdr_err=1 for exactly one cycle and the block bits are still emitted.
REQ-032 RST pulsed at seq=20 -> residue discarded; the next block is emitted starting at data_out[1:0]=sync_hdr.
